// File: rtl/bp_cfg_boot_loader_pkg.sv
// Shared cfg-link definitions for the tile boot loader: register indices,
// sequencer states and the write request record.
package bp_cfg_boot_loader_pkg;

    localparam int CFG_IDX_W  = 16;
    localparam int CFG_WORD_W = 64;

    localparam logic [CFG_IDX_W-1:0] REG_FREEZE      = 16'h0002;
    localparam logic [CFG_IDX_W-1:0] REG_CORE_ID     = 16'h0005;
    localparam logic [CFG_IDX_W-1:0] REG_DID         = 16'h0006;
    localparam logic [CFG_IDX_W-1:0] REG_CORD        = 16'h0007;
    localparam logic [CFG_IDX_W-1:0] REG_ICACHE_MODE = 16'h0022;
    localparam logic [CFG_IDX_W-1:0] REG_NPC         = 16'h0040;
    localparam logic [CFG_IDX_W-1:0] REG_DCACHE_MODE = 16'h0043;
    localparam logic [CFG_IDX_W-1:0] REG_CCE_MODE    = 16'h0081;
    localparam logic [CFG_IDX_W-1:0] UCODE_BASE      = 16'h8000;

    typedef logic [3:0] state_t;

    localparam state_t S_FREEZE   = 4'd0;
    localparam state_t S_IDS      = 4'd1;
    localparam state_t S_MODES    = 4'd2;
    localparam state_t S_CCE_UC   = 4'd3;
    localparam state_t S_UC_FETCH = 4'd4;
    localparam state_t S_UC_SEND  = 4'd5;
    localparam state_t S_NPC      = 4'd6;
    localparam state_t S_CCE_MODE = 4'd7;
    localparam state_t S_FENCE    = 4'd8;
    localparam state_t S_UNFREEZE = 4'd9;
    localparam state_t S_DRAIN    = 4'd10;
    localparam state_t S_DONE     = 4'd11;

    typedef struct packed {
        logic [CFG_IDX_W-1:0]  addr;
        logic [CFG_WORD_W-1:0] data;
    } cfg_write_t;

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Up/down counter of outstanding cfg writes with full, empty and underflow flags.
module bp_cfg_credit_counter #(
    parameter int credits_p   = 4,
    parameter int cnt_width_p = $clog2(credits_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o,
    output logic underflow_o
);

    logic [cnt_width_p-1:0] count_q, count_d;

    // A simultaneous send and acknowledge cancel out; an ack with nothing
    // outstanding leaves the count pinned at zero.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + cnt_width_p'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - cnt_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign full_o      = (count_q == cnt_width_p'(credits_p));
    assign empty_o     = (count_q == '0);
    assign underflow_o = dec_i & empty_o;

endmodule

// File: rtl/bp_cfg_boot_loader.sv
// Cfg-link initiator that walks a tile through its fixed boot write sequence,
// streaming CCE microcode from a ROM and fencing the final unfreeze.
module bp_cfg_boot_loader
    import bp_cfg_boot_loader_pkg::*;
#(
    parameter int                          cfg_addr_width_p = 40,
    parameter int                          cfg_data_width_p = 64,
    parameter logic [cfg_addr_width_p-1:0] cfg_base_addr_p  = 'h0100_0000,
    parameter int                          num_ucode_p      = 256,
    parameter int                          ucode_width_p    = 64,
    parameter int                          credits_p        = 4,
    parameter logic [CFG_WORD_W-1:0]       boot_pc_p        = 64'h8000_0000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [7:0]                  core_id_i,
    input  logic [7:0]                  did_i,
    input  logic [15:0]                 cord_i,
    input  logic [1:0]                  icache_mode_i,
    input  logic [1:0]                  dcache_mode_i,
    input  logic                        cce_mode_i,
    output logic                        ucode_r_v_o,
    output logic [11:0]                 ucode_addr_o,
    input  logic [ucode_width_p-1:0]    ucode_data_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_resp_v_i,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [11:0] UC_LAST = 12'((num_ucode_p > 0) ? (num_ucode_p - 1) : 0);

    state_t                   state_q, state_d;
    logic [11:0]              idx_q, idx_d;
    logic [ucode_width_p-1:0] ucData_q, ucData_d;
    logic                     ucLoaded_q, ucLoaded_d;
    logic                     err_q, err_d;
    logic                     creditFull, creditEmpty, creditUnderflow;
    logic                     writeState, xfer;
    cfg_write_t               req;

    bp_cfg_credit_counter #(
        .credits_p(credits_p)
    ) creditCounter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .inc_i      (xfer),
        .dec_i      (cfg_resp_v_i),
        .full_o     (creditFull),
        .empty_o    (creditEmpty),
        .underflow_o(creditUnderflow)
    );

    assign writeState = state_q inside {S_FREEZE, S_IDS, S_MODES, S_CCE_UC, S_UC_SEND,
                                        S_NPC, S_CCE_MODE, S_UNFREEZE};
    assign cfg_v_o      = writeState & ~creditFull & ~reset_i;
    assign xfer         = cfg_v_o & cfg_ready_i;
    assign ucode_r_v_o  = (state_q == S_UC_FETCH) & ~reset_i;
    assign ucode_addr_o = idx_q;
    assign done_o       = (state_q == S_DONE) & ~reset_i;
    assign err_o        = err_q;

    // The ROM word is live on the first send cycle and comes from the holding
    // register afterwards, so the request stays stable across a stall.
    always_comb begin
        req = '0;
        case (state_q)
            S_FREEZE: begin
                req.addr = REG_FREEZE;
                req.data = CFG_WORD_W'(1);
            end
            S_IDS: begin
                if (idx_q == 12'd0) begin
                    req.addr = REG_CORE_ID;
                    req.data = CFG_WORD_W'(core_id_i);
                end else if (idx_q == 12'd1) begin
                    req.addr = REG_DID;
                    req.data = CFG_WORD_W'(did_i);
                end else begin
                    req.addr = REG_CORD;
                    req.data = CFG_WORD_W'(cord_i);
                end
            end
            S_MODES: begin
                if (idx_q == 12'd0) begin
                    req.addr = REG_ICACHE_MODE;
                    req.data = CFG_WORD_W'(icache_mode_i);
                end else begin
                    req.addr = REG_DCACHE_MODE;
                    req.data = CFG_WORD_W'(dcache_mode_i);
                end
            end
            S_CCE_UC:   req.addr = REG_CCE_MODE;
            S_UC_SEND: begin
                req.addr = UCODE_BASE + CFG_IDX_W'(idx_q);
                req.data = CFG_WORD_W'(ucLoaded_q ? ucData_q : ucode_data_i);
            end
            S_NPC: begin
                req.addr = REG_NPC;
                req.data = boot_pc_p;
            end
            S_CCE_MODE: begin
                req.addr = REG_CCE_MODE;
                req.data = CFG_WORD_W'(cce_mode_i);
            end
            S_UNFREEZE: req.addr = REG_FREEZE;
            default:    req = '0;
        endcase
    end

    assign cfg_addr_o = cfg_base_addr_p + cfg_addr_width_p'(req.addr);
    assign cfg_data_o = cfg_data_width_p'(req.data);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ucData_d   = ucData_q;
        ucLoaded_d = ucLoaded_q;
        err_d      = err_q | creditUnderflow;
        case (state_q)
            S_FREEZE: if (xfer) state_d = S_IDS;
            S_IDS: if (xfer) begin
                if (idx_q == 12'd2) begin
                    state_d = S_MODES;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            S_MODES: if (xfer) begin
                if (idx_q == 12'd1) begin
                    state_d = S_CCE_UC;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            S_CCE_UC: if (xfer) state_d = (num_ucode_p == 0) ? S_NPC : S_UC_FETCH;
            S_UC_FETCH: begin
                state_d    = S_UC_SEND;
                ucLoaded_d = 1'b0;
            end
            S_UC_SEND: begin
                if (!ucLoaded_q) begin
                    ucLoaded_d = 1'b1;
                    ucData_d   = ucode_data_i;
                end
                if (xfer) begin
                    ucLoaded_d = 1'b0;
                    if (idx_q == UC_LAST) begin
                        state_d = S_NPC;
                        idx_d   = '0;
                    end else begin
                        state_d = S_UC_FETCH;
                        idx_d   = idx_q + 12'd1;
                    end
                end
            end
            S_NPC:      if (xfer) state_d = S_CCE_MODE;
            S_CCE_MODE: if (xfer) state_d = S_FENCE;
            S_FENCE:    if (creditEmpty) state_d = S_UNFREEZE;
            S_UNFREEZE: if (xfer) state_d = S_DRAIN;
            S_DRAIN:    if (creditEmpty) state_d = S_DONE;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_FREEZE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_FREEZE;
            idx_q      <= '0;
            ucData_q   <= '0;
            ucLoaded_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ucData_q   <= ucData_d;
            ucLoaded_q <= ucLoaded_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_bp_cfg_boot_loader.sv
// Randomized bench for bp_cfg_boot_loader: an ordered list of expected writes,
// a responder with programmable ack latency and a credit/error model.
module tb_bp_cfg_boot_loader;

    localparam int           ADDR_W  = 40;
    localparam int           DATA_W  = 64;
    localparam int           UC_W    = 64;
    localparam int           NUM_UC  = 4;
    localparam int           CREDITS = 2;
    localparam logic [39:0]  BASE    = 40'h0100_0000;
    localparam logic [63:0]  BOOT_PC = 64'h8000_0000;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } expWrite_t;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [7:0]        core_id_i, did_i;
    logic [15:0]       cord_i;
    logic [1:0]        icache_mode_i, dcache_mode_i;
    logic              cce_mode_i;
    logic              ucode_r_v_o;
    logic [11:0]       ucode_addr_o;
    logic [UC_W-1:0]   ucode_data_i;
    logic              cfg_v_o, cfg_ready_i;
    logic [ADDR_W-1:0] cfg_addr_o;
    logic [DATA_W-1:0] cfg_data_o;
    logic              cfg_resp_v_i, done_o, err_o;

    int compared = 0;
    int mismatched = 0;

    expWrite_t         expQ[$];
    int                ackQ[$];
    logic [UC_W-1:0]   rom[NUM_UC];
    int                cycle = 0, modelCount = 0, xferCount = 0, ucPulses = 0;
    int                ackMode = 0, ackBudget = -1, romAddr = 0;
    int                npcCycle = 0, unfreezeCycle = 0;
    bit                modelErr = 0, resetReq = 1, readyRandom = 0, forceResp = 0;
    bit                romPending = 0, prevStall = 0, doneSeen = 0;
    logic [ADDR_W-1:0] prevAddr;
    logic [DATA_W-1:0] prevData;

    bp_cfg_boot_loader #(
        .cfg_addr_width_p(ADDR_W),
        .cfg_data_width_p(DATA_W),
        .cfg_base_addr_p (BASE),
        .num_ucode_p     (NUM_UC),
        .ucode_width_p   (UC_W),
        .credits_p       (CREDITS),
        .boot_pc_p       (BOOT_PC)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .core_id_i    (core_id_i),
        .did_i        (did_i),
        .cord_i       (cord_i),
        .icache_mode_i(icache_mode_i),
        .dcache_mode_i(dcache_mode_i),
        .cce_mode_i   (cce_mode_i),
        .ucode_r_v_o  (ucode_r_v_o),
        .ucode_addr_o (ucode_addr_o),
        .ucode_data_i (ucode_data_i),
        .cfg_v_o      (cfg_v_o),
        .cfg_ready_i  (cfg_ready_i),
        .cfg_addr_o   (cfg_addr_o),
        .cfg_data_o   (cfg_data_o),
        .cfg_resp_v_i (cfg_resp_v_i),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushWrite(input logic [15:0] idx, input logic [63:0] data);
        expQ.push_back('{BASE + 40'(idx), data});
    endtask

    // The boot sequence as a flat list of register writes.
    task automatic buildExpected();
        expQ.delete();
        pushWrite(16'h0002, 64'd1);
        pushWrite(16'h0005, 64'(core_id_i));
        pushWrite(16'h0006, 64'(did_i));
        pushWrite(16'h0007, 64'(cord_i));
        pushWrite(16'h0022, 64'(icache_mode_i));
        pushWrite(16'h0043, 64'(dcache_mode_i));
        pushWrite(16'h0081, 64'd0);
        for (int i = 0; i < NUM_UC; i++) pushWrite(16'h8000 + 16'(i), rom[i]);
        pushWrite(16'h0040, BOOT_PC);
        pushWrite(16'h0081, 64'(cce_mode_i));
        pushWrite(16'h0002, 64'd0);
    endtask

    task automatic newConfig();
        core_id_i     = 8'($urandom);
        did_i         = 8'($urandom);
        cord_i        = 16'($urandom);
        icache_mode_i = 2'($urandom);
        dcache_mode_i = 2'($urandom);
        cce_mode_i    = 1'($urandom);
        for (int i = 0; i < NUM_UC; i++) rom[i] = {$urandom, $urandom};
    endtask

    function automatic int ackDelay(input logic [ADDR_W-1:0] addr);
        if (ackMode == 1) return $urandom_range(1, 6);
        if (ackMode == 2 && addr == BASE + 40'h40) return 12;
        return 1;
    endfunction

    // One clock: drive inputs just after the rising edge, observe on the falling edge.
    task automatic applyStimulus();
        expWrite_t w;
        bit        xfer, resp;
        @(posedge clk);
        #1;
        cycle++;
        reset_i      = resetReq;
        ucode_data_i = romPending ? rom[romAddr] : {$urandom, $urandom};
        cfg_ready_i  = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        cfg_resp_v_i = 1'b0;
        if (!resetReq) begin
            if (forceResp) begin
                cfg_resp_v_i = 1'b1;
            end else if (ackQ.size() > 0 && ackQ[0] <= cycle && ackBudget != 0) begin
                cfg_resp_v_i = 1'b1;
                void'(ackQ.pop_front());
                if (ackBudget > 0) ackBudget--;
            end
        end
        @(negedge clk);
        if (resetReq) begin
            checkOutput("reset_outs", {cfg_v_o, ucode_r_v_o, done_o}, 3'b000);
            modelCount = 0;
            modelErr   = 0;
            ackQ.delete();
            romPending = 0;
            prevStall  = 0;
            doneSeen   = 0;
            buildExpected();
        end else begin
            checkOutput("err_o", err_o, modelErr);
            if (modelCount == CREDITS) checkOutput("full_gate", cfg_v_o, 1'b0);
            if (prevStall) checkOutput("hold_stable", {cfg_v_o, cfg_addr_o, cfg_data_o},
                                       {1'b1, prevAddr, prevData});
            if (ucode_r_v_o) begin
                ucPulses++;
                if (expQ.size() > 0)
                    checkOutput("uc_addr", BASE + 40'h8000 + 40'(ucode_addr_o), expQ[0].addr);
                else
                    checkOutput("uc_extra", ucode_r_v_o, 1'b0);
            end
            xfer = cfg_v_o && cfg_ready_i;
            resp = cfg_resp_v_i;
            if (xfer) begin
                xferCount++;
                if (expQ.size() == 0) begin
                    checkOutput("extra_write", cfg_v_o, 1'b0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("write", {cfg_addr_o, cfg_data_o}, {w.addr, w.data});
                    if (w.addr == BASE + 40'h40) npcCycle = cycle;
                    if (expQ.size() == 0) begin
                        checkOutput("fence_count", modelCount, 0);
                        unfreezeCycle = cycle;
                    end
                    ackQ.push_back(cycle + ackDelay(w.addr));
                end
            end
            if (done_o && !doneSeen) begin
                doneSeen = 1;
                checkOutput("done_state", {expQ.size(), modelCount}, 0);
            end
            if (doneSeen) checkOutput("done_sticky", {done_o, cfg_v_o}, 2'b10);
            prevStall  = cfg_v_o && !cfg_ready_i;
            prevAddr   = cfg_addr_o;
            prevData   = cfg_data_o;
            romPending = ucode_r_v_o;
            romAddr    = int'(ucode_addr_o);
            if (resp && modelCount == 0) modelErr = 1;
            if (xfer && !resp) modelCount++;
            else if (resp && !xfer && modelCount > 0) modelCount--;
        end
    endtask

    task automatic runUntilDone(input int budget, input string tag);
        int n = 0;
        while (!done_o && n < budget) begin
            applyStimulus();
            n++;
        end
        if (!done_o) checkOutput(tag, done_o, 1'b1);
    endtask

    task automatic resetDut();
        resetReq = 1;
        repeat (2) applyStimulus();
        resetReq = 0;
    endtask

    initial begin
        reset_i      = 1'b1;
        cfg_ready_i  = 1'b0;
        cfg_resp_v_i = 1'b0;
        ucode_data_i = '0;
        newConfig();
        repeat (3) applyStimulus();
        resetReq = 0;

        $display("[TB] run A: always ready, ack one cycle after each write");
        xferCount = 0;
        ucPulses  = 0;
        runUntilDone(300, "timeout_a");
        checkOutput("uc_reads", ucPulses, NUM_UC);
        checkOutput("write_count", xferCount, 7 + NUM_UC + 3);

        $display("[TB] stray ack with nothing outstanding");
        forceResp = 1;
        applyStimulus();
        forceResp = 0;
        repeat (3) applyStimulus();
        checkOutput("err_sticky", {err_o, done_o}, 2'b11);

        $display("[TB] run B: credit stall, then random ready and ack latency");
        newConfig();
        resetDut();
        ackBudget = 0;
        xferCount = 0;
        repeat (8) applyStimulus();
        checkOutput("credit_limit", xferCount, CREDITS);
        checkOutput("credit_stall", cfg_v_o, 1'b0);
        ackBudget = 1;
        repeat (8) applyStimulus();
        checkOutput("credit_release", xferCount, CREDITS + 1);
        ackBudget   = -1;
        ackMode     = 1;
        readyRandom = 1;
        runUntilDone(3000, "timeout_b");

        $display("[TB] run C: NPC ack held back");
        newConfig();
        readyRandom = 0;
        ackMode     = 2;
        resetDut();
        runUntilDone(300, "timeout_c");
        checkOutput("fence_hold", unfreezeCycle > npcCycle + 13, 1'b1);

        $display("[TB] run D: reset while sending ucode word 2");
        newConfig();
        ackMode = 0;
        resetDut();
        begin
            int n = 0;
            while (!(ucode_r_v_o && ucode_addr_o == 12'd2) && n < 100) begin
                applyStimulus();
                n++;
            end
        end
        if (!(ucode_r_v_o && ucode_addr_o == 12'd2)) checkOutput("uc2_seen", ucode_r_v_o, 1'b1);
        resetDut();
        applyStimulus();
        checkOutput("restart", {cfg_v_o, cfg_addr_o, cfg_data_o, done_o},
                    {1'b1, BASE + 40'h2, 64'h1, 1'b0});
        runUntilDone(300, "timeout_d");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
